pipelined_rc_addsub: RTL and testbench

//  Parametrised, pipelined ripple-carry adder/subtractor; successor to the fixed 64-bit RCA.

---
 rtl/pipelined_rc_addsub_pkg.sv | 12 +
 rtl/pipelined_rc_addsub_if.sv | 32 +++
 rtl/pipelined_rc_addsub_chunk.sv | 29 ++
 rtl/pipelined_rc_addsub.sv | 105 ++++++++++
 tb/tb_pipelined_rc_addsub.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_rc_addsub_pkg.sv
// Shared constants and operation encoding for the pipelined adder/subtractor.
package addsub_pkg;

  localparam int unsigned DEF_WIDTH  = 64;
  localparam int unsigned DEF_STAGES = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

endpackage

// File: rtl/pipelined_rc_addsub_if.sv
// Streaming valid/ready bundle: operand side in, result side out.
interface pipelined_rc_addsub_if
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side (drives operands, accepts results).
  modport master (
    output in_valid, in1, in2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Arithmetic block side.
  modport slave (
    input  in_valid, in1, in2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_rc_addsub_chunk.sv
// Combinational ripple of CHUNK full adders; also exposes the carry into the chunk MSB.
module rca_chunk #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  // Bit-serial carry ripple across the chunk.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_rc_addsub.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry registered between.
module pipelined_rc_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_rc_addsub_if.slave bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;

  // acc_q rotates right by CHUNK each stage: pending A chunks drain from the bottom
  // while finished sum chunks enter at the top, so after the last stage it is the sum.
  logic [WIDTH-1:0] acc_q [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] vld_q;
  logic              ovf_q;

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] v_src;
  logic [CHUNK-1:0] s_chk [STAGES];
  logic [STAGES-1:0] co_chk;
  logic             cm_chk [STAGES];
  logic [STAGES-1:0] en;

  logic             is_sub;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

  // Subtraction is A + ~B + 1; cin only matters for add.
  assign is_sub = (bus.sub == MODE_SUB);
  assign b_in   = is_sub ? ~bus.in2 : bus.in2;
  assign c_in   = is_sub ? 1'b1 : bus.cin;

  // Load enables: a stage may load when empty or when its successor moves on.
  always_comb begin
    en           = '0;
    en[STAGES-1] = !vld_q[STAGES-1] || bus.out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      en[k] = !vld_q[k] || en[k+1];
    end
  end

  // Per-stage source selection and chunk adder.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_src[k] = bus.in1;
      assign b_src[k] = b_in;
      assign c_src[k] = c_in;
      assign v_src[k] = bus.in_valid;
    end else begin : g_next
      assign a_src[k] = acc_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign v_src[k] = vld_q[k-1];
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a     (a_src[k][CHUNK-1:0]),
      .b     (b_src[k][k*CHUNK +: CHUNK]),
      .cin   (c_src[k]),
      .sum   (s_chk[k]),
      .cout  (co_chk[k]),
      .c_msb (cm_chk[k])
    );
  end

  // Stage registers; a stalled stage simply holds its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_q[k] <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld_q[k] <= v_src[k];
          acc_q[k] <= WIDTH'({s_chk[k], a_src[k]} >> CHUNK);
          b_q[k]   <= b_src[k];
          c_q[k]   <= co_chk[k];
        end
      end
      if (en[STAGES-1]) begin
        ovf_q <= co_chk[STAGES-1] ^ cm_chk[STAGES-1];
      end
    end
  end

  assign bus.in_ready  = en[0];
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = acc_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rc_addsub.sv
// Self-checking bench: three DUT depths (4, 1, 64) run the same directed/random plan.
module tb_pipelined_rc_addsub;
  import addsub_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned CW = W + 2;

  typedef struct packed {
    logic         cout;
    logic         ovf;
    logic [W-1:0] sum;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int           sel;
  int           cur_s;
  logic         tv;
  logic [W-1:0] tin1, tin2;
  logic         tcin, tsub, tordy;

  pipelined_rc_addsub_if #(.WIDTH(W)) if4  ();
  pipelined_rc_addsub_if #(.WIDTH(W)) if1  ();
  pipelined_rc_addsub_if #(.WIDTH(W)) if64 ();

  assign if4.in_valid  = tv && (sel == 0);
  assign if4.in1       = tin1;
  assign if4.in2       = tin2;
  assign if4.cin       = tcin;
  assign if4.sub       = tsub;
  assign if4.out_ready = tordy;
  assign if1.in_valid  = tv && (sel == 1);
  assign if1.in1       = tin1;
  assign if1.in2       = tin2;
  assign if1.cin       = tcin;
  assign if1.sub       = tsub;
  assign if1.out_ready = tordy;
  assign if64.in_valid  = tv && (sel == 2);
  assign if64.in1       = tin1;
  assign if64.in2       = tin2;
  assign if64.cin       = tcin;
  assign if64.sub       = tsub;
  assign if64.out_ready = tordy;

  pipelined_rc_addsub #(.WIDTH(W), .STAGES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
  pipelined_rc_addsub #(.WIDTH(W), .STAGES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
  pipelined_rc_addsub #(.WIDTH(W), .STAGES(64)) u_dut64 (.clk(clk), .rst(rst), .bus(if64));

  logic         ob_in_ready, ob_out_valid, ob_cout, ob_ovf;
  logic [W-1:0] ob_sum;

  // Observe whichever DUT the current plan pass targets.
  always_comb begin
    ob_in_ready  = if4.in_ready;
    ob_out_valid = if4.out_valid;
    ob_sum       = if4.sum;
    ob_cout      = if4.cout;
    ob_ovf       = if4.ovf;
    if (sel == 1) begin
      ob_in_ready  = if1.in_ready;
      ob_out_valid = if1.out_valid;
      ob_sum       = if1.sum;
      ob_cout      = if1.cout;
      ob_ovf       = if1.ovf;
    end else if (sel == 2) begin
      ob_in_ready  = if64.in_ready;
      ob_out_valid = if64.out_valid;
      ob_sum       = if64.sum;
      ob_cout      = if64.cout;
      ob_ovf       = if64.ovf;
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  res_t q[$];
  res_t pend;
  logic last_rdy, last_ov, last_acc, last_drn;
  res_t last_out;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 65-bit unsigned and sign-extended arithmetic.
  function automatic res_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input logic s);
    res_t         o;
    logic [W:0]   u;
    logic [W+1:0] sr;
    if (!s) begin
      u      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      o.sum  = u[W-1:0];
      o.cout = u[W];
      sr     = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b} + {{(W+1){1'b0}}, c};
    end else begin
      o.sum  = a - b;
      o.cout = (a >= b);
      sr     = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b};
    end
    o.ovf = (sr[W] != sr[W-1]);
    return o;
  endfunction

  // One clock: sample away from the edge, score handshakes, advance.
  task automatic cyc();
    res_t e;
    #1;
    last_rdy = ob_in_ready;
    last_ov  = ob_out_valid;
    last_out = {ob_cout, ob_ovf, ob_sum};
    last_acc = tv && ob_in_ready && !rst;
    last_drn = ob_out_valid && tordy && !rst;
    if (last_drn) begin
      if (q.size() == 0) chk("spurious_out", CW'(ob_out_valid), CW'(1'b0));
      else begin
        e = q.pop_front();
        chk("result", CW'(last_out), CW'(e));
      end
    end
    if (last_acc) q.push_back(pend);
    @(posedge clk);
    if (rst) q.delete();
    @(negedge clk);
  endtask

  task automatic set_rand();
    tin1 = {$urandom(), $urandom()};
    tin2 = {$urandom(), $urandom()};
    tcin = 1'($urandom_range(0, 1));
    tsub = 1'($urandom_range(0, 1));
    pend = ref_model(tin1, tin2, tcin, tsub);
  endtask

  // Send one item into an empty pipe, time its latency, then drain it.
  task automatic send_timed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic c, input logic s, input res_t exp);
    int lat;
    tin1 = a; tin2 = b; tcin = c; tsub = s; pend = exp;
    tv = 1'b1; tordy = 1'b1;
    cyc();
    chk({tag, "_accept"}, CW'(last_acc), CW'(1'b1));
    tv = 1'b0;
    lat = 1;
    for (int i = 0; i < cur_s + 4; i++) begin
      #1;
      if (ob_out_valid) break;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, CW'(lat), CW'(cur_s));
    cyc();
  endtask

  task automatic run_plan();
    int   cnt;
    res_t held;
    logic [CW:0] held_v;
    bit   have_held;

    // Reset with in_valid high.
    tordy = 1'b1; set_rand(); tv = 1'b1; rst = 1'b1;
    cyc(); cyc();
    tv = 1'b0; rst = 1'b0;
    #1;
    chk("rst_out_valid", CW'(ob_out_valid), CW'(1'b0));
    chk("rst_outputs", CW'({ob_cout, ob_ovf, ob_sum}), CW'(0));
    chk("rst_in_ready", CW'(ob_in_ready), CW'(1'b1));

    // Directed corner vectors.
    send_timed("add_carry_all", {W{1'b1}}, W'(1), 1'b0, MODE_ADD,
               {1'b1, 1'b0, 64'h0000_0000_0000_0000});
    send_timed("sub_ovf", 64'h8000_0000_0000_0000, W'(1), 1'b0, MODE_SUB,
               {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF});
    send_timed("sub_borrow", W'(5), W'(7), 1'b0, MODE_SUB,
               {1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
    send_timed("sub_cin_ignored", W'(9), W'(4), 1'b1, MODE_SUB,
               {1'b1, 1'b0, 64'h0000_0000_0000_0005});

    // Back-to-back random stream at full rate.
    cnt = 0;
    tordy = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_rand(); tv = 1'b1;
      cyc();
      chk("stream_in_ready", CW'(last_rdy), CW'(1'b1));
      if (last_drn) cnt++;
    end
    tv = 1'b0;
    chk("stream_drains", CW'(cnt), CW'(100 - cur_s));
    cnt = 0;
    for (int i = 0; i < cur_s; i++) begin
      cyc();
      if (last_drn) cnt++;
    end
    chk("stream_tail", CW'(cnt), CW'(cur_s));

    // Backpressure for 10 cycles with input offered every cycle.
    tordy = 1'b0; cnt = 0; have_held = 1'b0; held_v = '0;
    for (int i = 0; i < 10; i++) begin
      set_rand(); tv = 1'b1;
      cyc();
      if (last_acc) cnt++;
      if (last_ov) begin
        if (!have_held) begin
          held = last_out; have_held = 1'b1;
          held_v = {1'b1, CW'(held)};
        end else chk("bp_hold", CW'(last_out), held_v[CW-1:0]);
      end
    end
    tv = 1'b0;
    chk("bp_accepts", CW'(cnt), CW'((cur_s < 10) ? cur_s : 10));
    #1;
    if (cur_s < 10) chk("bp_in_ready", CW'(ob_in_ready), CW'(1'b0));
    tordy = 1'b1;
    for (int i = 0; i < cur_s + 20; i++) begin
      if (q.size() == 0) break;
      cyc();
    end
    chk("bp_leftover", CW'(q.size()), CW'(0));

    // Mid-flight reset discards three queued items.
    tordy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_rand(); tv = 1'b1;
      cyc();
    end
    tv = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("mf_out_valid", CW'(ob_out_valid), CW'(1'b0));
    tordy = 1'b1;
    for (int i = 0; i < cur_s + 2; i++) cyc();
    set_rand();
    send_timed("mf_new", tin1, tin2, tcin, tsub, pend);
    chk("mf_leftover", CW'(q.size()), CW'(0));
  endtask

  initial begin
    rst = 1'b1; tv = 1'b0; tordy = 1'b1;
    tin1 = '0; tin2 = '0; tcin = 1'b0; tsub = 1'b0;
    pend = '0; sel = 0; cur_s = 4;
    @(negedge clk);

    sel = 0; cur_s = 4;  run_plan();
    sel = 1; cur_s = 1;  run_plan();
    sel = 2; cur_s = 64; run_plan();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
